midi_rx_parser: RTL and testbench

//  Serial MIDI front end for the FM synth: receives the 31250-baud 8N1 MIDI line
//  and assembles complete channel-voice messages. Presents each message to the

---
 rtl/midi_rx_parser_if.sv | 38 +++
 rtl/midi_rx_parser.sv | 176 +++++++++++++++++
 tb/tb_midi_rx_parser.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/midi_rx_parser_if.sv
// MIDI receiver bus: the serial line into the parser and the assembled-message
// outputs back to the synth dispatcher, plus a view of the receive FSM state.
//
// Strobe protocol: IO_MIDI_ready is a one-cycle valid with no ready/back-pressure
// path; the consumer must take IO_MIDI_byte_0/1/2 in the cycle ready is high.
// The byte outputs are stable from that cycle until the next ready strobe.
// IO_MIDI_frame_err is an independent one-cycle event strobe.
interface midi_rx_parser_if;
   logic       IO_MIDI_rx;
   logic       IO_MIDI_ready;
   logic [7:0] IO_MIDI_byte_0;
   logic [7:0] IO_MIDI_byte_1;
   logic [7:0] IO_MIDI_byte_2;
   logic       IO_MIDI_frame_err;
   logic [2:0] rx_state_dbg;

   // Line driver / message consumer side.
   modport master (
      output IO_MIDI_rx,
      input  IO_MIDI_ready,
      input  IO_MIDI_byte_0,
      input  IO_MIDI_byte_1,
      input  IO_MIDI_byte_2,
      input  IO_MIDI_frame_err,
      input  rx_state_dbg
   );

   // Parser side.
   modport slave (
      input  IO_MIDI_rx,
      output IO_MIDI_ready,
      output IO_MIDI_byte_0,
      output IO_MIDI_byte_1,
      output IO_MIDI_byte_2,
      output IO_MIDI_frame_err,
      output rx_state_dbg
   );
endinterface

// File: rtl/midi_rx_parser.sv
// MIDI 8N1 receiver and channel-voice message assembler.
// The UART half samples the synchronized line at mid-bit; the parser half
// applies running status and emits complete messages with a one-cycle strobe.
module midi_rx_parser #(
   parameter int CLKS_PER_BIT = 384
) (
   input logic              IO_main_clk,
   input logic              IO_reset,
   midi_rx_parser_if.slave  midi
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_HIGH = 3'd4
   } rx_state_t;

   rx_state_t        rx_state;
   logic             rx_m;
   logic             rx_s;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic [7:0]       rx_byte;
   logic             stop_ok;
   logic             byte_valid;

   logic             status_ok;
   logic [7:0]       status_reg;
   logic             two_data;
   logic             data_cnt;
   logic [7:0]       data_1;

   assign midi.rx_state_dbg = rx_state;

   // Two-flop synchronizer; preset high so reset release never looks like a start bit.
   always_ff @(posedge IO_main_clk or posedge IO_reset) begin
      if (IO_reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= midi.IO_MIDI_rx;
         rx_s <= rx_m;
      end
   end

   // Receive FSM: start-bit qualification at half a bit, then one sample per bit time.
   always_ff @(posedge IO_main_clk or posedge IO_reset) begin
      if (IO_reset) begin
         rx_state               <= S_IDLE;
         bit_cnt                <= '0;
         bit_idx                <= '0;
         shift_reg              <= '0;
         rx_byte                <= '0;
         stop_ok                <= 1'b0;
         midi.IO_MIDI_frame_err <= 1'b0;
      end else begin
         stop_ok                <= 1'b0;
         midi.IO_MIDI_frame_err <= 1'b0;
         case (rx_state)
            S_IDLE: begin
               bit_cnt <= '0;
               if (!rx_s) rx_state <= S_START;
            end
            S_START: begin
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  // A line already back high at mid start bit was only a glitch.
                  rx_state <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt   <= '0;
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  if (bit_idx == 3'd7) rx_state <= S_STOP;
                  else                 bit_idx  <= bit_idx + 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  if (rx_s) begin
                     rx_byte  <= shift_reg;
                     stop_ok  <= 1'b1;
                     rx_state <= S_IDLE;
                  end else begin
                     midi.IO_MIDI_frame_err <= 1'b1;
                     rx_state               <= S_WAIT_HIGH;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               // A held-low break must not re-trigger start detection.
               bit_cnt <= '0;
               if (rx_s) rx_state <= S_IDLE;
            end
            default: begin
               bit_cnt  <= '0;
               rx_state <= S_IDLE;
            end
         endcase
      end
   end

   // One-cycle byte-valid pulse, issued the cycle after a good stop sample.
   always_ff @(posedge IO_main_clk or posedge IO_reset) begin
      if (IO_reset) byte_valid <= 1'b0;
      else          byte_valid <= stop_ok;
   end

   // Message parser: running status, realtime pass-through, data slotting.
   always_ff @(posedge IO_main_clk or posedge IO_reset) begin
      if (IO_reset) begin
         status_ok           <= 1'b0;
         status_reg          <= '0;
         two_data            <= 1'b0;
         data_cnt            <= 1'b0;
         data_1              <= '0;
         midi.IO_MIDI_ready  <= 1'b0;
         midi.IO_MIDI_byte_0 <= '0;
         midi.IO_MIDI_byte_1 <= '0;
         midi.IO_MIDI_byte_2 <= '0;
      end else begin
         midi.IO_MIDI_ready <= 1'b0;
         if (byte_valid) begin
            if (rx_byte[7]) begin
               if (rx_byte < 8'hF0) begin
                  // Channel-voice status: program change and channel pressure carry one data byte.
                  status_ok  <= 1'b1;
                  status_reg <= rx_byte;
                  two_data   <= !((rx_byte[7:4] == 4'hC) || (rx_byte[7:4] == 4'hD));
                  data_cnt   <= 1'b0;
               end else if (rx_byte < 8'hF8) begin
                  // System common / SysEx: nothing until a fresh channel status arrives.
                  status_ok <= 1'b0;
                  data_cnt  <= 1'b0;
               end
               // 0xF8-0xFF realtime: leave all parser state untouched.
            end else if (status_ok) begin
               if (!data_cnt) begin
                  data_1 <= rx_byte;
                  if (two_data) begin
                     data_cnt <= 1'b1;
                  end else begin
                     midi.IO_MIDI_ready  <= 1'b1;
                     midi.IO_MIDI_byte_0 <= status_reg;
                     midi.IO_MIDI_byte_1 <= rx_byte;
                     midi.IO_MIDI_byte_2 <= 8'h00;
                  end
               end else begin
                  data_cnt            <= 1'b0;
                  midi.IO_MIDI_ready  <= 1'b1;
                  midi.IO_MIDI_byte_0 <= status_reg;
                  midi.IO_MIDI_byte_1 <= data_1;
                  midi.IO_MIDI_byte_2 <= rx_byte;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_midi_rx_parser.sv
// Bench for midi_rx_parser: table of byte streams with expected messages,
// then hand-written sequences for framing errors, glitches and mid-byte reset.
module tb_midi_rx_parser;

   localparam int C = 16;            // clocks per bit (short bit time keeps the run small)
   localparam int H = C / 2;
   // Start-edge drive to ready seen at the following negedge: 2 sync flops,
   // 1 cycle to leave IDLE, half-bit start check, 8 data + stop bit times,
   // 2 stages to the ready register, plus the sampling negedge.
   localparam int LAT = 2 + 1 + H + 9 * C + 2 + 1 - 1;

   typedef struct packed {
      logic [3:0]  n;       // number of bytes sent
      logic [63:0] b;       // bytes, first byte in the top octet
      logic [1:0]  n_exp;   // messages expected
      logic [47:0] e;       // expected {b0,b1,b2} messages, first in the top half
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   midi_rx_parser_if bus();

   midi_rx_parser #(.CLKS_PER_BIT(C)) dut (
      .IO_main_clk (clk),
      .IO_reset    (rst),
      .midi        (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_start = 0;
   int          rdy_cnt = 0;
   int          ferr_cnt = 0;
   logic [23:0] exp_q[$];
   logic [23:0] held = '0;
   logic        prev_ready = 1'b0;
   vec_t        vecs[8];

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      bus.IO_MIDI_rx = 1'b0;
      last_start = cyc;
      tick(C);
      for (int i = 0; i < 8; i++) begin
         bus.IO_MIDI_rx = b[i];
         tick(C);
      end
      bus.IO_MIDI_rx = stop_bit;
      tick(C);
   endtask

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic drain(input string name);
      tick(20);
      check({name, " pending"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         held       = '0;
         prev_ready = 1'b0;
      end else begin
         if (bus.IO_MIDI_ready) begin
            rdy_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ready: got %02h/%02h/%02h expected none",
                        bus.IO_MIDI_byte_0, bus.IO_MIDI_byte_1, bus.IO_MIDI_byte_2);
            end else begin
               logic [23:0] want;
               want = exp_q.pop_front();
               if ({bus.IO_MIDI_byte_0, bus.IO_MIDI_byte_1, bus.IO_MIDI_byte_2} !== want) begin
                  errors++;
                  $display("FAIL message: got %02h/%02h/%02h expected %06h",
                           bus.IO_MIDI_byte_0, bus.IO_MIDI_byte_1, bus.IO_MIDI_byte_2, want);
               end
            end
            checks++;
            if (cyc - last_start != LAT) begin
               errors++;
               $display("FAIL ready_latency: got %0d expected %0d", cyc - last_start, LAT);
            end
            held = {bus.IO_MIDI_byte_0, bus.IO_MIDI_byte_1, bus.IO_MIDI_byte_2};
         end else if ({bus.IO_MIDI_byte_0, bus.IO_MIDI_byte_1, bus.IO_MIDI_byte_2} !== held) begin
            errors++;
            $display("FAIL byte_hold: got %02h/%02h/%02h expected %06h",
                     bus.IO_MIDI_byte_0, bus.IO_MIDI_byte_1, bus.IO_MIDI_byte_2, held);
         end
         if (prev_ready && bus.IO_MIDI_ready) begin
            errors++;
            $display("FAIL ready_width: got 2+ cycles expected 1");
         end
         prev_ready = bus.IO_MIDI_ready;
         if (bus.IO_MIDI_frame_err) ferr_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int r0;
      int f0;
      vecs[0] = '{4'd3, 64'h90_3C_64_00_00_00_00_00, 2'd1, 48'h903C64_000000};
      vecs[1] = '{4'd5, 64'h90_3C_64_40_00_00_00_00, 2'd2, 48'h903C64_904000};
      vecs[2] = '{4'd3, 64'hC5_07_21_00_00_00_00_00, 2'd2, 48'hC50700_C52100};
      vecs[3] = '{4'd8, 64'h80_3C_F8_40_F0_01_02_10, 2'd1, 48'h803C40_000000};
      vecs[4] = '{4'd2, 64'h3C_64_00_00_00_00_00_00, 2'd0, 48'h000000_000000};
      vecs[5] = '{4'd2, 64'hD3_55_00_00_00_00_00_00, 2'd1, 48'hD35500_000000};
      vecs[6] = '{4'd3, 64'hB0_07_7F_00_00_00_00_00, 2'd1, 48'hB0077F_000000};
      vecs[7] = '{4'd5, 64'hF8_E2_00_FF_40_00_00_00, 2'd1, 48'hE20040_000000};

      // clock/reset
      rst = 1'b1;
      bus.IO_MIDI_rx = 1'b1;
      tick(5);
      check("reset_ready", bus.IO_MIDI_ready, 0);
      check("reset_bytes", {bus.IO_MIDI_byte_0, bus.IO_MIDI_byte_1, bus.IO_MIDI_byte_2}, 0);
      check("reset_ferr", bus.IO_MIDI_frame_err, 0);
      check("reset_state", bus.rx_state_dbg, 0);
      rst = 1'b0;
      tick(5);

      // table-driven byte streams, bytes sent back to back
      for (int v = 0; v < 8; v++) begin
         for (int k = 0; k < int'(vecs[v].n_exp); k++)
            exp_q.push_back(vecs[v].e[47 - 24*k -: 24]);
         for (int i = 0; i < int'(vecs[v].n); i++)
            send_byte(vecs[v].b[63 - 8*i -: 8], 1'b1);
         drain($sformatf("vec%0d", v));
      end

      // framing error on a data byte, then a held-low break
      r0 = rdy_cnt;
      f0 = ferr_cnt;
      send_byte(8'h90, 1'b1);
      send_byte(8'h3C, 1'b0);
      tick(5 * C);
      bus.IO_MIDI_rx = 1'b1;
      tick(3 * C);
      check("frame_err_count", ferr_cnt - f0, 1);
      check("frame_err_no_ready", rdy_cnt - r0, 0);
      exp_q.push_back(24'h903C64);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h64, 1'b1);
      drain("after_frame_err");

      // quarter-bit glitch must not produce a byte
      r0 = rdy_cnt;
      f0 = ferr_cnt;
      bus.IO_MIDI_rx = 1'b0;
      tick(C / 4);
      bus.IO_MIDI_rx = 1'b1;
      tick(3 * C);
      check("glitch_state", bus.rx_state_dbg, 0);
      check("glitch_no_ready", rdy_cnt - r0, 0);
      check("glitch_no_ferr", ferr_cnt - f0, 0);
      exp_q.push_back(24'h903C64);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h64, 1'b1);
      drain("after_glitch");

      // reset in the middle of a byte
      bus.IO_MIDI_rx = 1'b0;
      tick(C + 3 * C);
      check("pre_reset_state", bus.rx_state_dbg, 2);
      rst = 1'b1;
      bus.IO_MIDI_rx = 1'b1;
      tick(3);
      check("midreset_ready", bus.IO_MIDI_ready, 0);
      check("midreset_bytes", {bus.IO_MIDI_byte_0, bus.IO_MIDI_byte_1, bus.IO_MIDI_byte_2}, 0);
      check("midreset_ferr", bus.IO_MIDI_frame_err, 0);
      check("midreset_state", bus.rx_state_dbg, 0);
      rst = 1'b0;
      tick(2 * C);
      r0 = rdy_cnt;
      send_byte(8'h3C, 1'b1);
      send_byte(8'h40, 1'b1);
      tick(20);
      check("no_status_after_reset", rdy_cnt - r0, 0);
      exp_q.push_back(24'h903C64);
      send_byte(8'h90, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h64, 1'b1);
      drain("after_reset");

      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
